// File: rtl/vend_controller.sv
// Vending controller: coin credit, dispense, change and timeout refund.
// Optional cancel input enabled by defining VEND_CANCEL_EN.
module vend_controller #(
  parameter int unsigned PRICE_Q      = 4,
  parameter int unsigned MAX_CREDIT_Q = 8,
  parameter int unsigned TIMEOUT      = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] coin,
  input  logic       sel,
  input  logic       disp_ack,
  input  logic       change_ack,
`ifdef VEND_CANCEL_EN
  input  logic       cancel,
`endif
  output logic       pr_en,
  output logic       change_req,
  output logic [3:0] change_q,
  output logic [3:0] credit_q,
  output logic       coin_reject,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CREDIT,
    S_DISPENSE,
    S_CHANGE,
    S_REFUND
  } state_t;

  localparam logic [3:0] LP_PRICE = 4'(PRICE_Q);
  localparam logic [4:0] LP_MAX   = 5'(MAX_CREDIT_Q);
  localparam logic [7:0] LP_TO_M1 = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic [3:0] r_credit;
  logic [7:0] r_idle;
  logic       r_pr;
  logic       r_chg_req;
  logic [3:0] r_chg_q;
  logic       r_rej;
  logic       r_busy;

  state_t     w_state_n;
  logic [3:0] w_credit_n;
  logic [7:0] w_idle_n;
  logic       w_pr_n;
  logic       w_chg_req_n;
  logic [3:0] w_chg_q_n;
  logic       w_rej_n;
  logic       w_busy_n;

  logic [3:0] w_coin_val;
  logic       w_coin_vld;
  logic [4:0] w_sum;
  logic       w_fits;
  logic       w_timeout;
  logic       w_can_buy;
  logic [3:0] w_rem;
  logic       w_cancel;

`ifdef VEND_CANCEL_EN
  assign w_cancel = cancel;
`else
  assign w_cancel = 1'b0;
`endif

  // Decode the coin code into quarters
  always_comb begin
    w_coin_val = 4'd0;
    unique case (coin)
      2'b00:   w_coin_val = 4'd1;
      2'b01:   w_coin_val = 4'd2;
      2'b10:   w_coin_val = 4'd4;
      default: w_coin_val = 4'd0;
    endcase
  end

  assign w_coin_vld = (coin != 2'b11);
  assign w_sum      = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_fits     = (w_sum <= LP_MAX);
  assign w_timeout  = (r_idle >= LP_TO_M1);
  assign w_can_buy  = (r_credit >= LP_PRICE);
  assign w_rem      = r_credit - LP_PRICE;

  // Next-state and next-output computation
  always_comb begin
    w_state_n   = r_state;
    w_credit_n  = r_credit;
    w_idle_n    = r_idle;
    w_pr_n      = r_pr;
    w_chg_req_n = r_chg_req;
    w_chg_q_n   = r_chg_q;
    w_rej_n     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_idle_n = 8'd0;
        if (w_coin_vld) begin
          if (w_fits) begin
            w_credit_n = w_sum[3:0];
            w_state_n  = S_CREDIT;
          end else begin
            w_rej_n = 1'b1;
          end
        end
      end
      S_CREDIT: begin
        if (w_coin_vld && w_fits) begin
          w_credit_n = w_sum[3:0];
          w_idle_n   = 8'd0;
        end else if (!w_coin_vld && w_cancel) begin
          w_state_n   = S_REFUND;
          w_chg_req_n = 1'b1;
          w_chg_q_n   = r_credit;
          w_idle_n    = 8'd0;
        end else if (!w_coin_vld && sel && w_can_buy) begin
          w_state_n = S_DISPENSE;
          w_pr_n    = 1'b1;
          w_idle_n  = 8'd0;
        end else begin
          w_rej_n = w_coin_vld;
          if (w_timeout) begin
            w_state_n   = S_REFUND;
            w_chg_req_n = 1'b1;
            w_chg_q_n   = r_credit;
            w_idle_n    = 8'd0;
          end else begin
            w_idle_n = r_idle + 8'd1;
          end
        end
      end
      S_DISPENSE: begin
        w_rej_n = w_coin_vld;
        if (disp_ack) begin
          w_pr_n     = 1'b0;
          w_credit_n = w_rem;
          if (w_rem != 4'd0) begin
            w_state_n   = S_CHANGE;
            w_chg_req_n = 1'b1;
            w_chg_q_n   = w_rem;
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end
      S_CHANGE, S_REFUND: begin
        w_rej_n = w_coin_vld;
        if (change_ack) begin
          w_credit_n  = 4'd0;
          w_chg_q_n   = 4'd0;
          w_chg_req_n = 1'b0;
          w_state_n   = S_IDLE;
        end
      end
      default: begin
        w_state_n   = S_IDLE;
        w_credit_n  = 4'd0;
        w_idle_n    = 8'd0;
        w_pr_n      = 1'b0;
        w_chg_req_n = 1'b0;
        w_chg_q_n   = 4'd0;
      end
    endcase
    w_busy_n = (w_state_n == S_DISPENSE) ||
               (w_state_n == S_CHANGE) ||
               (w_state_n == S_REFUND);
  end

  // State and registered outputs; reset discards held credit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_credit  <= 4'd0;
      r_idle    <= 8'd0;
      r_pr      <= 1'b0;
      r_chg_req <= 1'b0;
      r_chg_q   <= 4'd0;
      r_rej     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_credit  <= w_credit_n;
      r_idle    <= w_idle_n;
      r_pr      <= w_pr_n;
      r_chg_req <= w_chg_req_n;
      r_chg_q   <= w_chg_q_n;
      r_rej     <= w_rej_n;
      r_busy    <= w_busy_n;
    end
  end

  assign pr_en       = r_pr;
  assign change_req  = r_chg_req;
  assign change_q    = r_chg_q;
  assign credit_q    = r_credit;
  assign coin_reject = r_rej;
  assign busy        = r_busy;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with default parameters.
// Expected values are hand-computed per step.
module tb_vend_controller;

  logic       clock;
  logic       reset;
  logic [1:0] coin;
  logic       sel;
  logic       disp_ack;
  logic       change_ack;
`ifdef VEND_CANCEL_EN
  logic       cancel;
`endif
  logic       pr_en;
  logic       change_req;
  logic [3:0] change_q;
  logic [3:0] credit_q;
  logic       coin_reject;
  logic       busy;

  int checks = 0;
  int errors = 0;

  vend_controller dut (
    .clock       (clock),
    .reset       (reset),
    .coin        (coin),
    .sel         (sel),
    .disp_ack    (disp_ack),
    .change_ack  (change_ack),
`ifdef VEND_CANCEL_EN
    .cancel      (cancel),
`endif
    .pr_en       (pr_en),
    .change_req  (change_req),
    .change_q    (change_q),
    .credit_q    (credit_q),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b0;
    coin       = 2'b11;
    sel        = 1'b0;
    disp_ack   = 1'b0;
    change_ack = 1'b0;
`ifdef VEND_CANCEL_EN
    cancel     = 1'b0;
`endif
    #2 reset = 1'b1;
    #1;
    chk("rst_pr", 8'(pr_en), 8'd0);
    chk("rst_creq", 8'(change_req), 8'd0);
    chk("rst_cq", 8'(change_q), 8'd0);
    chk("rst_cred", 8'(credit_q), 8'd0);
    chk("rst_rej", 8'(coin_reject), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    tick();
    tick();
    reset = 1'b0;

    // acks in IDLE are ignored
    disp_ack = 1'b1; change_ack = 1'b1;
    tick();
    chk("idle_ack_busy", 8'(busy), 8'd0);
    chk("idle_ack_cred", 8'(credit_q), 8'd0);
    disp_ack = 1'b0; change_ack = 1'b0;

    // 50 + 50, buy, exact price
    coin = 2'b01; tick();
    chk("s1_cred2", 8'(credit_q), 8'd2);
    chk("s1_busy0", 8'(busy), 8'd0);
    tick();
    chk("s1_cred4", 8'(credit_q), 8'd4);
    coin = 2'b11; sel = 1'b1; tick();
    chk("s1_pr1", 8'(pr_en), 8'd1);
    chk("s1_busy1", 8'(busy), 8'd1);
    sel = 1'b0; tick();
    chk("s1_pr2", 8'(pr_en), 8'd1);
    tick();
    chk("s1_pr3", 8'(pr_en), 8'd1);
    tick();
    chk("s1_pr4", 8'(pr_en), 8'd1);
    chk("s1_creq_dis", 8'(change_req), 8'd0);
    disp_ack = 1'b1; tick();
    chk("s1_pr_drop", 8'(pr_en), 8'd0);
    chk("s1_cred0", 8'(credit_q), 8'd0);
    chk("s1_creq0", 8'(change_req), 8'd0);
    chk("s1_busy_end", 8'(busy), 8'd0);
    disp_ack = 1'b0; tick();
    chk("s1_idle_creq", 8'(change_req), 8'd0);

    // 100 + 50, buy, change 2
    coin = 2'b10; tick();
    chk("s2_cred4", 8'(credit_q), 8'd4);
    coin = 2'b01; tick();
    chk("s2_cred6", 8'(credit_q), 8'd6);
    coin = 2'b11; sel = 1'b1; tick();
    chk("s2_pr", 8'(pr_en), 8'd1);
    sel = 1'b0; disp_ack = 1'b1; tick();
    chk("s2_pr0", 8'(pr_en), 8'd0);
    chk("s2_creq", 8'(change_req), 8'd1);
    chk("s2_cq", 8'(change_q), 8'd2);
    chk("s2_cred", 8'(credit_q), 8'd2);
    disp_ack = 1'b0; tick();
    chk("s2_creq_hold", 8'(change_req), 8'd1);
    chk("s2_busy", 8'(busy), 8'd1);
    change_ack = 1'b1; tick();
    chk("s2_creq_clr", 8'(change_req), 8'd0);
    chk("s2_cq_clr", 8'(change_q), 8'd0);
    chk("s2_cred_clr", 8'(credit_q), 8'd0);
    chk("s2_busy_clr", 8'(busy), 8'd0);
    change_ack = 1'b0;

    // coin and sel together, then overflow reject
    coin = 2'b10; tick();
    chk("s3_cred4", 8'(credit_q), 8'd4);
    sel = 1'b1; tick();
    chk("s3_cred8", 8'(credit_q), 8'd8);
    chk("s3_pr0", 8'(pr_en), 8'd0);
    chk("s3_busy0", 8'(busy), 8'd0);
    sel = 1'b0; coin = 2'b00; tick();
    chk("s3_rej", 8'(coin_reject), 8'd1);
    chk("s3_cred_keep", 8'(credit_q), 8'd8);
    coin = 2'b11; tick();
    chk("s3_rej_pulse", 8'(coin_reject), 8'd0);
    chk("s3_cred_still", 8'(credit_q), 8'd8);
    sel = 1'b1; tick();
    chk("s3_pr", 8'(pr_en), 8'd1);
    sel = 1'b0; disp_ack = 1'b1; tick();
    chk("s3_cq4", 8'(change_q), 8'd4);
    chk("s3_creq", 8'(change_req), 8'd1);
    chk("s3_pr_off", 8'(pr_en), 8'd0);
    disp_ack = 1'b0; change_ack = 1'b1; tick();
    chk("s3_done", 8'(change_req), 8'd0);
    change_ack = 1'b0;

    // timeout refund, coin during refund rejected
    coin = 2'b00; tick();
    chk("s4_cred1", 8'(credit_q), 8'd1);
    coin = 2'b11;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("s4_wait", 8'(change_req), 8'd0);
    end
    tick();
    chk("s4_refund", 8'(change_req), 8'd1);
    chk("s4_cq1", 8'(change_q), 8'd1);
    chk("s4_busy", 8'(busy), 8'd1);
    coin = 2'b01; tick();
    chk("s4_rej", 8'(coin_reject), 8'd1);
    chk("s4_cred_keep", 8'(credit_q), 8'd1);
    coin = 2'b11; tick();
    chk("s4_rej_off", 8'(coin_reject), 8'd0);
    change_ack = 1'b1; tick();
    chk("s4_done", 8'(change_req), 8'd0);
    chk("s4_cred0", 8'(credit_q), 8'd0);
    change_ack = 1'b0;

    // reset between edges while dispensing
    coin = 2'b10; tick();
    coin = 2'b11; sel = 1'b1; tick();
    chk("s5_pr", 8'(pr_en), 8'd1);
    sel = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("s5_pr_async", 8'(pr_en), 8'd0);
    chk("s5_cred_async", 8'(credit_q), 8'd0);
    chk("s5_busy_async", 8'(busy), 8'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("s5_pr_after", 8'(pr_en), 8'd0);
    chk("s5_busy_after", 8'(busy), 8'd0);
    coin = 2'b01; tick();
    chk("s5_idle_load", 8'(credit_q), 8'd2);
    coin = 2'b11;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 The block SHALL provide parameter PRICE_Q, default 4, meaning the product price in 25-cent units.
REQ-002 The block SHALL provide parameter MAX_CREDIT_Q, default 8, meaning the maximum credit held in 25-cent units (PRICE_Q <= MAX_CREDIT_Q <= 15).
REQ-003 The block SHALL provide parameter TIMEOUT, default 5, meaning the number of idle cycles in CREDIT before an automatic refund (1..255).
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 coin  input  2  coin code: 2'b00=25, 2'b01=50, 2'b10=100, 2'b11=no coin; sampled every cycle.
REQ-007 sel  input  1  purchase request, level-sampled.
REQ-008 disp_ack  input  1  dispenser has delivered the product.
REQ-009 change_ack  input  1  change mechanism has paid out change_q.
REQ-010 pr_en  output  1  dispense request to the dispenser.
REQ-011 change_req  output  1  change/refund payout request.
REQ-012 change_q  output  4  payout amount in 25-cent units, valid while change_req=1.
REQ-013 credit_q  output  4  current credit in 25-cent units.
REQ-014 coin_reject  output  1  one-cycle pulse: the coin sampled in the previous cycle was returned, not credited.
REQ-015 busy  output  1  high in DISPENSE, CHANGE and REFUND.

Function
REQ-016 The FSM SHALL have the states IDLE, CREDIT, DISPENSE, CHANGE and REFUND; all outputs SHALL be registered.
REQ-017 Coin value in quarters: 00->1, 01->2, 10->4, 11->0 (no coin).
REQ-018 IDLE: on a valid coin, credit_q SHALL load the coin value and the FSM SHALL go to CREDIT; sel SHALL be ignored.
REQ-019 CREDIT: on a valid coin with credit_q+value <= MAX_CREDIT_Q, the coin value SHALL be added; otherwise credit_q SHALL be unchanged and coin_reject SHALL pulse the next cycle.
REQ-020 CREDIT: when sel=1, coin=11 and credit_q >= PRICE_Q, the FSM SHALL go to DISPENSE; pr_en SHALL be 1 starting on the next cycle.
REQ-021 CREDIT: a coin and sel in the same cycle SHALL process the coin only; sel SHALL be dropped.
REQ-022 CREDIT: sel with credit_q < PRICE_Q SHALL be ignored and SHALL count as an idle cycle.
REQ-023 CREDIT: an idle counter SHALL clear on any accepted coin and increment on every cycle without an accepted coin or a successful sel.
REQ-024 When the idle counter reaches TIMEOUT, the FSM SHALL go to REFUND.
REQ-025 DISPENSE: pr_en SHALL be held at 1 until disp_ack=1. Then credit_q SHALL become credit_q-PRICE_Q and pr_en SHALL drop. The FSM SHALL go to CHANGE if the remainder is nonzero; otherwise it SHALL go to IDLE.
REQ-026 CHANGE/REFUND: change_req SHALL be 1 with change_q=credit_q until change_ack=1. Then credit_q, change_q and change_req SHALL clear and the FSM SHALL return to IDLE.
REQ-027 Any valid coin sampled in DISPENSE, CHANGE or REFUND SHALL be rejected (coin_reject pulse, credit unchanged).
REQ-028 disp_ack outside DISPENSE and change_ack outside CHANGE/REFUND SHALL be ignored.
REQ-029 pr_en and change_req SHALL never be 1 simultaneously.
REQ-030 credit_q SHALL never exceed MAX_CREDIT_Q; no arithmetic SHALL wrap.

Reset
REQ-031 Asserting reset SHALL force the FSM to IDLE at any time, including mid-DISPENSE or mid-CHANGE, independent of clock.
REQ-032 Under reset, all outputs SHALL be 0 and the idle counter SHALL be 0; credit held at reset SHALL be discarded.

Configuration
REQ-033 When VEND_CANCEL_EN is defined, the block SHALL have an extra input port cancel (1 bit). Asserting cancel in CREDIT with no coin SHALL move the FSM to REFUND on the next edge; cancel in other states SHALL be ignored.
REQ-034 When VEND_CANCEL_EN is undefined, the cancel port SHALL be absent and REFUND SHALL be reached only by timeout.

Verification
REQ-035 The bench SHALL cover this scenario: coins 50, 50 then sel, disp_ack after 3 cycles -> credit_q 2, 4, pr_en for 4 cycles, credit_q 0, IDLE, no change_req.
REQ-036 The bench SHALL cover this scenario: coins 100, 50 then sel, disp_ack -> pr_en, then change_req=1 with change_q=2 until change_ack, then IDLE.
REQ-037 The bench SHALL cover this scenario: credit 8, then coin 25 -> coin_reject pulse one cycle later, credit_q stays 8.
REQ-038 The bench SHALL cover this scenario: coin 25, then no activity for 5 cycles -> REFUND, change_q=1; coin 50 during REFUND -> coin_reject.
REQ-039 The bench SHALL cover this scenario: reset asserted mid-DISPENSE between clock edges -> pr_en=0 and credit_q=0 immediately, IDLE after release.
REQ-040 The bench SHALL cover this scenario: coin 100 and sel in the same cycle from credit 4 -> credit_q 8, stay in CREDIT, pr_en=0.
